// File: rtl/decode_writeback.sv
// decode_writeback: Y86 SEQ decode/write-back stage with a 15 x WIDTH register file and sticky status
//   in : clk, rst (async, active-high), icode/rA/rB from fetch, imem_error, cnd, valE, valM, dbg_sel
//   out: valA = R[srcA], valB = R[srcB], stat (0 AOK, 1 HLT, 2 ADR, 3 INS), dbg_val = R[dbg_sel]
//   Register ID 4'hF is RNONE: it reads as 0 and is never written.
module decode_writeback #(
  parameter int NREGS = 15,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             imem_error,
  input  logic             cnd,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic [1:0]       stat,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_val
);
  typedef enum logic [1:0] {AOK, HLT, ADR, INS} stat_e;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP = 4'h4;
  logic [WIDTH-1:0] regs_q [NREGS];
  stat_e stat_q, stat_d;
  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic we;
  always_comb begin
    src_a = (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? rA : (icode inside {4'h9, 4'hB}) ? RSP : RNONE;
    src_b = (icode inside {4'h4, 4'h5, 4'h6}) ? rB : (icode inside {[4'h8:4'hB]}) ? RSP : RNONE;
    dst_e = (icode inside {4'h3, 4'h6} || (icode == 4'h2 && cnd)) ? rB :
            (icode inside {[4'h8:4'hB]}) ? RSP : RNONE;
    dst_m = (icode inside {4'h5, 4'hB}) ? rA : RNONE;
    stat_d = stat_q != AOK ? stat_q : imem_error ? ADR : icode > 4'hB ? INS : icode == 4'h0 ? HLT : AOK;
    // stat_d stays AOK only when already AOK and the current instruction is legal
    we = stat_d == AOK;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= AOK;
    else stat_q <= stat_d;
  end
  // dstM is tested first so valM wins when both destinations name the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NREGS; i++)
        if (dst_m == 4'(i)) regs_q[i] <= valM;
        else if (dst_e == 4'(i)) regs_q[i] <= valE;
    end
  end
  assign valA = src_a == RNONE ? '0 : regs_q[src_a];
  assign valB = src_b == RNONE ? '0 : regs_q[src_b];
  assign dbg_val = dbg_sel == RNONE ? '0 : regs_q[dbg_sel];
  assign stat = stat_q;
endmodule

// File: tb/tb_decode_writeback.sv
// tb_decode_writeback: directed self-checking bench for decode_writeback
module tb_decode_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, rA, rB, dbg_sel;
  logic        imem_error, cnd;
  logic [63:0] valE, valM, valA, valB, dbg_val;
  logic [1:0]  stat;
  int errs = 0;
  int checks = 0;

  decode_writeback dut (
    .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB),
    .imem_error(imem_error), .cnd(cnd), .valE(valE), .valM(valM),
    .valA(valA), .valB(valB), .stat(stat), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] id, input logic [63:0] exp);
    dbg_sel = id;
    #1;
    chk(tag, dbg_val, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] e, input logic [63:0] m);
    icode = ic; rA = a; rB = b; valE = e; valM = m;
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    chk("rst_stat", 64'(stat), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_error = 1'b0; cnd = 1'b0; dbg_sel = 4'h0;
    drive(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    #13 rst = 1'b0;
    chk("reset_stat", 64'(stat), 64'd0);
    for (int i = 0; i < 16; i++) chk_reg($sformatf("reset_r%0d", i), 4'(i), 64'd0);
    step();
    // irmovq $10, %rdx; not visible before the edge
    drive(4'h3, 4'hF, 4'h2, 64'd10, 64'd0);
    chk_reg("irmov_pre", 4'h2, 64'd0);
    step();
    chk_reg("irmov_r2", 4'h2, 64'd10);
    // OPq %rdx, %rdx reads 10 on both ports, then writes valE
    drive(4'h6, 4'h2, 4'h2, 64'd20, 64'd0);
    #1;
    chk("opq_valA", valA, 64'd10);
    chk("opq_valB", valB, 64'd10);
    step();
    chk_reg("opq_r2", 4'h2, 64'd20);
    // nop with rA=2: srcA is RNONE so valA reads 0
    drive(4'h1, 4'h2, 4'h2, 64'd0, 64'd0);
    #1;
    chk("nop_valA", valA, 64'd0);
    chk_reg("dbg_f", 4'hF, 64'd0);
    // cmovXX %rax, %rbp
    cnd = 1'b0;
    drive(4'h2, 4'h0, 4'h5, 64'd7, 64'd0);
    step();
    chk_reg("cmov_nc", 4'h5, 64'd0);
    cnd = 1'b1;
    step();
    chk_reg("cmov_c", 4'h5, 64'd7);
    cnd = 1'b0;
    // popq %rsp: valM wins over valE
    drive(4'hB, 4'h4, 4'hF, 64'h100, 64'hDEAD);
    step();
    chk_reg("popq_rsp", 4'h4, 64'hDEAD);
    // pushq %rdx: valA=R2, valB=RSP, RSP <- valE
    drive(4'hA, 4'h2, 4'hF, 64'hDEA5, 64'd0);
    #1;
    chk("push_valA", valA, 64'd20);
    chk("push_valB", valB, 64'hDEAD);
    step();
    chk_reg("push_rsp", 4'h4, 64'hDEA5);
    // mrmovq: R3 <- valM, valB = R4
    drive(4'h5, 4'h3, 4'h4, 64'd0, 64'd55);
    #1;
    chk("mrmov_valB", valB, 64'hDEA5);
    step();
    chk_reg("mrmov_r3", 4'h3, 64'd55);
    // halt stops writes and sticks
    drive(4'h0, 4'hF, 4'h1, 64'd9, 64'd0);
    step();
    chk("halt_stat", 64'(stat), 64'd1);
    chk_reg("halt_r1", 4'h1, 64'd0);
    drive(4'h3, 4'hF, 4'h1, 64'd9, 64'd0);
    step();
    chk("halt_sticky", 64'(stat), 64'd1);
    chk_reg("halt_r1b", 4'h1, 64'd0);
    pulse_rst();
    chk_reg("rst_r2", 4'h2, 64'd0);
    chk_reg("rst_r4", 4'h4, 64'd0);
    // illegal icode
    drive(4'hC, 4'hF, 4'h6, 64'd5, 64'd0);
    step();
    chk("ins_stat", 64'(stat), 64'd3);
    chk_reg("ins_r6", 4'h6, 64'd0);
    drive(4'h3, 4'hF, 4'h6, 64'd5, 64'd0);
    step();
    chk("ins_sticky", 64'(stat), 64'd3);
    chk_reg("ins_r6b", 4'h6, 64'd0);
    pulse_rst();
    // fetch address error beats a legal irmovq
    imem_error = 1'b1;
    step();
    chk("adr_stat", 64'(stat), 64'd2);
    chk_reg("adr_r6", 4'h6, 64'd0);
    imem_error = 1'b0;
    pulse_rst();
    // write, then reset between edges clears immediately
    drive(4'h3, 4'hF, 4'h7, 64'd77, 64'd0);
    step();
    chk_reg("pre_rst_r7", 4'h7, 64'd77);
    #2 rst = 1'b1;
    #1;
    chk_reg("mid_rst_r7", 4'h7, 64'd0);
    // an edge while rst is held performs no write
    step();
    chk_reg("rst_edge_r7", 4'h7, 64'd0);
    rst = 1'b0;
    chk("final_stat", 64'(stat), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
